// File: rtl/dm_pkg.sv
// Shared types and helpers for the debug module system bus access master.
package dm_pkg;

    typedef enum logic [2:0] {
        None    = 3'd0,
        Timeout = 3'd1,
        BadAddr = 3'd2,
        Align   = 3'd3,
        Size    = 3'd4
    } sberror_e;

    typedef enum logic [2:0] {
        Idle,
        Read,
        Write,
        WaitRead,
        WaitWrite
    } sba_state_e;

    // Byte enables for a 2^size-byte access at byte offset addr on a width-bit bus.
    function automatic logic [7:0] sba_be(input logic [2:0] addr, input logic [2:0] size,
                                          input int unsigned width);
        logic [7:0] be;
        be = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < width / 8 && i >= 32'(addr) && i < 32'(addr) + (32'd1 << size)) begin
                be[i] = 1'b1;
            end
        end
        return be;
    endfunction

endpackage

// File: rtl/dm_sba_lanes.sv
// Combinational lane handling for one SBA beat: write replication, byte enables,
// and right-aligned, size-masked read extraction.
module dm_sba_lanes
    import dm_pkg::*;
#(
    parameter int unsigned BusWidth = 32
) (
    input  logic [2:0]            i_offset,
    input  logic [2:0]            i_size,
    input  logic [BusWidth-1:0]   i_wdata,
    input  logic [BusWidth-1:0]   i_rdata,
    output logic [BusWidth-1:0]   o_wdata,
    output logic [BusWidth/8-1:0] o_be,
    output logic [BusWidth-1:0]   o_rdata
);

    localparam int unsigned NumBytes = BusWidth / 8;

    logic [BusWidth-1:0] w_mask;

    always_comb begin
        o_wdata = '0;
        for (int unsigned i = 0; i < NumBytes; i++) begin
            o_wdata[8*i +: 8] = i_wdata[8*(i & ((32'd1 << i_size) - 32'd1)) +: 8];
        end
    end

    assign o_be = (BusWidth/8)'(sba_be(i_offset, i_size, BusWidth));

    // A shift of the full bus width yields zero, so the mask becomes all ones.
    assign w_mask  = (BusWidth'(1) << (32'd8 << i_size)) - BusWidth'(1);
    assign o_rdata = (i_rdata >> {i_offset, 3'b000}) & w_mask;

endmodule

// File: rtl/dm_sba_ext.sv
// System Bus Access master: turns sbaddress/sbdata events into single-beat bus
// requests with size/alignment/response/timeout/busy error reporting.
module dm_sba_ext
    import dm_pkg::*;
#(
    parameter int unsigned BusWidth      = 32,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned TimeoutCycles = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   dmactive_i,
    output logic                   master_req_o,
    output logic [AddrWidth-1:0]   master_add_o,
    output logic                   master_we_o,
    output logic [BusWidth-1:0]    master_wdata_o,
    output logic [BusWidth/8-1:0]  master_be_o,
    input  logic                   master_gnt_i,
    input  logic                   master_r_valid_i,
    input  logic                   master_r_err_i,
    input  logic [BusWidth-1:0]    master_r_rdata_i,
    input  logic [AddrWidth-1:0]   sbaddress_i,
    input  logic                   sbaddress_write_valid_i,
    input  logic                   sbreadonaddr_i,
    input  logic                   sbautoincrement_i,
    input  logic [2:0]             sbaccess_i,
    input  logic                   sbreadondata_i,
    input  logic [BusWidth-1:0]    sbdata_i,
    input  logic                   sbdata_read_valid_i,
    input  logic                   sbdata_write_valid_i,
    output logic [AddrWidth-1:0]   sbaddress_o,
    output logic [BusWidth-1:0]    sbdata_o,
    output logic                   sbdata_valid_o,
    output logic                   sbbusy_o,
    output logic                   sbbusyerror_o,
    output logic                   sberror_valid_o,
    output logic [2:0]             sberror_o
);

    localparam int unsigned CntW    = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
    localparam int unsigned CntLast = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;

    sba_state_e            r_state, w_state_nxt;
    logic [AddrWidth-1:0]  r_addr;
    logic [2:0]            r_size;
    logic [BusWidth-1:0]   r_wdata;
    logic [CntW-1:0]       r_cnt;
    logic                  w_launch, w_busy, w_trig_wr, w_trig_rd;
    logic                  w_size_err, w_align_err, w_resp, w_timeout;
    logic [2:0]            w_off;
    logic [BusWidth/8-1:0] w_be;

    assign w_busy      = (r_state != Idle);
    assign w_trig_wr   = sbdata_write_valid_i;
    assign w_trig_rd   = (sbdata_read_valid_i && sbreadondata_i)
                      || (sbaddress_write_valid_i && sbreadonaddr_i);
    assign w_size_err  = (32'd8 << sbaccess_i) > BusWidth;
    assign w_align_err = (64'(sbaddress_i) & ((64'd1 << sbaccess_i) - 64'd1)) != '0;
    assign w_resp      = master_r_valid_i && (r_state == WaitRead || r_state == WaitWrite);
    // The response takes precedence over a timeout landing in the same cycle.
    assign w_timeout   = (TimeoutCycles != 0) && w_busy && !w_resp && (r_cnt == CntW'(CntLast));
    assign w_off       = 3'(r_addr & AddrWidth'(BusWidth / 8 - 1));

    dm_sba_lanes #(
        .BusWidth (BusWidth)
    ) u_lanes (
        .i_offset (w_off),
        .i_size   (r_size),
        .i_wdata  (r_wdata),
        .i_rdata  (master_r_rdata_i),
        .o_wdata  (master_wdata_o),
        .o_be     (w_be),
        .o_rdata  (sbdata_o)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_launch        = 1'b0;
        master_req_o    = 1'b0;
        sbdata_valid_o  = 1'b0;
        sbbusyerror_o   = 1'b0;
        sberror_valid_o = 1'b0;
        sberror_o       = None;
        sbaddress_o     = sbaddress_i;
        if (!dmactive_i) begin
            w_state_nxt = Idle;
        end else begin
            unique case (r_state)
                Idle: begin
                    if (w_trig_wr || w_trig_rd) begin
                        if (w_size_err) begin
                            sberror_valid_o = 1'b1;
                            sberror_o       = Size;
                        end else if (w_align_err) begin
                            sberror_valid_o = 1'b1;
                            sberror_o       = Align;
                        end else begin
                            w_launch    = 1'b1;
                            w_state_nxt = w_trig_wr ? Write : Read;
                        end
                    end
                end
                Read, Write: begin
                    if (w_timeout) begin
                        sberror_valid_o = 1'b1;
                        sberror_o       = Timeout;
                        w_state_nxt     = Idle;
                    end else begin
                        master_req_o = 1'b1;
                        if (master_gnt_i) begin
                            w_state_nxt = (r_state == Read) ? WaitRead : WaitWrite;
                        end
                    end
                end
                WaitRead, WaitWrite: begin
                    if (w_resp) begin
                        w_state_nxt = Idle;
                        if (master_r_err_i) begin
                            sberror_valid_o = 1'b1;
                            sberror_o       = BadAddr;
                        end else begin
                            sbdata_valid_o = (r_state == WaitRead);
                            if (sbautoincrement_i) begin
                                sbaddress_o = r_addr + AddrWidth'(64'd1 << r_size);
                            end
                        end
                    end else if (w_timeout) begin
                        sberror_valid_o = 1'b1;
                        sberror_o       = Timeout;
                        w_state_nxt     = Idle;
                    end
                end
                default: w_state_nxt = Idle;
            endcase
            if (w_busy && (sbaddress_write_valid_i || sbdata_read_valid_i || sbdata_write_valid_i)) begin
                sbbusyerror_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= Idle;
            r_addr  <= '0;
            r_size  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_launch) begin
                r_addr  <= sbaddress_i;
                r_size  <= sbaccess_i;
                r_wdata <= sbdata_i;
            end
            if (w_launch || w_state_nxt == Idle) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign master_add_o = r_addr;
    assign master_we_o  = (r_state == Write);
    assign master_be_o  = master_req_o ? w_be : '0;
    assign sbbusy_o     = w_busy;

endmodule

// File: doc/dm_sba_ext.md
# dm_sba_ext

Parametrised System Bus Access master for the debug module. It turns debugger sbaddress/sbdata register events into single-beat requests on a generic req/gnt/r_valid bus of 32 or 64 bits, with separate address width. It also adds response-error, timeout, alignment and busy-error reporting, and latches each request's attributes. It sits between the DM register file (which owns the sbcs fields) and the SoC bus.

## Interface
- BusWidth, 32: data width, 32 or 64.
- AddrWidth, 32: address width, 1..64, independent of BusWidth.
- TimeoutCycles, 0: cycles allowed from request launch to response; 0 disables the timeout.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- dmactive_i  in  1  synchronous active-low clear: abort to Idle.
- master_req_o / master_add_o / master_we_o  out  1 / AddrWidth / 1  request, address, write enable.
- master_wdata_o / master_be_o  out  BusWidth / BusWidth/8  lane-replicated write data and byte enables.
- master_gnt_i / master_r_valid_i / master_r_err_i  in  1  grant, response valid, response error.
- master_r_rdata_i  in  BusWidth  read data.
- sbaddress_i  in  AddrWidth  current sbaddress.
- sbaddress_write_valid_i / sbreadonaddr_i / sbautoincrement_i / sbreadondata_i  in  1  control events and flags.
- sbaccess_i  in  3  log2 of access size in bytes.
- sbdata_i  in  BusWidth  write data, right-aligned.
- sbdata_read_valid_i / sbdata_write_valid_i  in  1  debugger read or write of sbdata0.
- sbaddress_o  out  AddrWidth  next sbaddress; equals sbaddress_i except in an autoincrement completion cycle.
- sbdata_o / sbdata_valid_o  out  BusWidth / 1  right-aligned, zero-extended read data and its strobe.
- sbbusy_o  out  1  state != Idle.
- sbbusyerror_o  out  1  one-cycle pulse: new event arrived while busy.
- sberror_valid_o / sberror_o  out  1 / 3  one-cycle error pulse and its code.

## Operation
- States: Idle, Read, Write, WaitRead, WaitWrite.
- Trigger priority in Idle: sbdata_write_valid_i (write), then sbdata_read_valid_i&&sbreadondata_i (read), then sbaddress_write_valid_i&&sbreadonaddr_i (read).
- On trigger, launch checks run in the same cycle:
  - size: 8·2^sbaccess_i must be ≤ BusWidth, else code 4.
  - alignment: sbaddress_i must be aligned to size, else code 3.
  - On either failure: pulse the error, stay Idle, issue no request.
- On a clean launch: latch address, size, we and sbdata_i into registers. Go to Read or Write.
- Later changes to sbaccess_i, sbaddress_i or sbdata_i do not affect the transaction in flight.
- Read/Write: master_req_o=1 until master_gnt_i, then go to WaitRead/WaitWrite.
- Wait states: on master_r_valid_i, return to Idle.
  - If master_r_err_i=1: error code 2. sbdata_valid_o=0 for writes and for errored reads; address not incremented.
  - Else for a read: sbdata_valid_o=1 and sbdata_o = (rdata >> 8·offset), masked to size. offset = addr[log2(BusWidth/8)-1:0].
  - Else, if sbautoincrement_i: sbaddress_o = latched address + 2^size, modulo 2^AddrWidth, for that cycle only.
- Write lanes: the low size bytes of sbdata are replicated across the bus. master_be_o has size consecutive bits set starting at offset.
- Timeout: a counter of $clog2(TimeoutCycles+1) bits clears at launch and increments in Read/Write/Wait.
  - On reaching TimeoutCycles without completion: code 1, drop req, go to Idle.
  - A response arriving later while Idle is ignored.
- Busy error: any trigger while state != Idle pulses sbbusyerror_o and is discarded. This includes sbaddress_write_valid_i regardless of sbreadonaddr_i.
- dmactive_i=0: next state Idle, counter cleared, no error pulse. Responses arriving while Idle are ignored.

## Timing
- Reset values: state Idle, all outputs 0 except sbaddress_o = sbaddress_i and sbdata_o = masked rdata (combinational).
- Trigger at cycle T gives master_req_o=1 from T+1.
- With gnt at T+1 and r_valid at T+2: sbdata_valid_o and sbaddress_o update at T+2, sbbusy_o=0 at T+3.
- Minimum turnaround is 3 cycles per access.
- gnt and r_valid in the same cycle as req (zero-latency slave) is illegal. r_valid is only sampled in Wait states.
- Response and timeout in the same cycle: the response wins, no timeout error.
- A trigger in the completion cycle is still busy and gives sbbusyerror_o.
- Error codes and data strobes are combinational pulses, exactly one cycle wide.

## Structure
- Package dm_pkg gets:
  - sberror_e: None=0, Timeout=1, BadAddr=2, Align=3, Size=4.
  - sba_state_e.
  - function sba_be(addr, size, width).
- Sub-module dm_sba_lanes holds the combinational write replication, byte-enable generation and read extraction/masking. It is instantiated once and kept separate for reuse by a future burst SBA.

## Test plan
- BusWidth=64, 4-byte write to 0x1004, sbdata_i=0xAABBCCDD -> master_be_o=0xF0, master_wdata_o=0xAABBCCDD_AABBCCDD, no error.
- BusWidth=32, 2-byte readonaddr at 0x102, rdata=0x12345678, autoincrement -> sbdata_o=0x1234, sbaddress_o=0x104 in the r_valid cycle.
- 4-byte read at 0x1001 -> sberror_o=3 pulse, master_req_o never asserted. sbaccess_i=3 with BusWidth=32 -> code 4.
- TimeoutCycles=8, gnt given, no r_valid -> sberror_o=1 at launch+8, Idle. A late r_valid is ignored with sbdata_valid_o=0.
- Write in flight, sbdata_write_valid_i pulsed -> sbbusyerror_o=1 for one cycle and the original write is unchanged. master_r_err_i=1 on completion -> code 2, address not incremented.
- dmactive_i=0 during WaitRead, then response -> Idle next cycle, no sbdata_valid_o. rst_ni low mid-Write -> req drops asynchronously.
